alu32_req_sched: RTL and testbench

- Shares one ALU32 instance between two independent requesters.
- Arbitrates round-robin and issues one operation at a time. Holds operands stable for the ALU's registered latency, captures the result and carry, and returns them to the owning requester.
- Handshakes on both sides are valid/ready. Divide-by-zero is intercepted so it never reaches the ALU.

---
 rtl/alu32_req_sched.sv | 204 ++++++++++++++++++++
 tb/tb_alu32_req_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_req_sched.sv
// Round-robin scheduler sharing one registered-latency ALU32 between two valid/ready requesters.
// Divide-by-zero requests are answered locally and never reach the ALU operand registers.
module alu32_req_sched #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_func,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_func,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_func,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             busy
);

    localparam int         CNT_W    = 4;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_ptr;
    logic             r_owner;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_func;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_carry;
    logic             r_rsp_err;
    logic [TAG_W-1:0] r_rsp_tag;

    logic             w_any;
    logic             w_grant;
    logic             w_accept;
    logic             w_div0;
    logic             w_cnt_done;
    logic             w_rsp_ack;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [3:0]       w_sel_func;
    logic [TAG_W-1:0] w_sel_tag;

    // Pointer side wins when valid; otherwise the other side, so a waiting requester never starves.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_any   = 1'b0;
        w_grant = r_ptr;
        if (r_ptr ? req1_valid : req0_valid) begin
            w_any   = 1'b1;
            w_grant = r_ptr;
        end else if (r_ptr ? req0_valid : req1_valid) begin
            w_any   = 1'b1;
            w_grant = ~r_ptr;
        end
    end

    always_comb begin
        w_sel_a    = w_grant ? req1_a    : req0_a;
        w_sel_b    = w_grant ? req1_b    : req0_b;
        w_sel_func = w_grant ? req1_func : req0_func;
        w_sel_tag  = w_grant ? req1_tag  : req0_tag;
    end

    assign w_accept   = (r_state == S_IDLE) && w_any && !rst;
    assign w_div0     = (w_sel_func == FUNC_DIV) && (w_sel_b == '0);
    assign w_cnt_done = (r_cnt == CNT_W'(ALU_LAT));
    assign w_rsp_ack  = r_owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                req0_ready = w_accept && !w_grant;
                req1_ready = w_accept &&  w_grant;
                if (w_accept) begin
                    w_next_state = w_div0 ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_cnt_done) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                rsp0_valid = !r_owner;
                rsp1_valid =  r_owner;
                if (w_rsp_ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand registers only move on a non-div0 accept, so a forced response leaves the ALU untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_func  <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_tag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant;
                        r_ptr   <= ~w_grant;
                        r_tag   <= w_sel_tag;
                        if (w_div0) begin
                            r_rsp_data  <= '1;
                            r_rsp_carry <= 1'b0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_tag   <= w_sel_tag;
                        end else begin
                            r_alu_a    <= w_sel_a;
                            r_alu_b    <= w_sel_b;
                            r_alu_func <= w_sel_func;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= CNT_W'(1);
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_cnt_done) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_carry <= alu_carry;
                        r_rsp_err   <= 1'b0;
                        r_rsp_tag   <= r_tag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_func  = r_alu_func;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_err   = r_rsp_err;
    assign rsp_tag   = r_rsp_tag;

endmodule

// File: tb/tb_alu32_req_sched.sv
// Self-checking bench: transaction-level model of arbitration, latency and results,
// with a behavioural ALU32 stand-in; second instance exercises a 3-cycle ALU.
module tb_alu32_req_sched;

    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_func, req1_func, req0_tag, req1_tag;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry, rsp_err;
    logic [3:0]  rsp_tag;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_func;
    logic        alu_carry, busy;

    logic        d3_req0_valid, d3_req0_ready, d3_req1_ready;
    logic [31:0] d3_req0_a, d3_req0_b;
    logic [3:0]  d3_req0_func, d3_req0_tag;
    logic        d3_rsp0_valid, d3_rsp1_valid, d3_rsp0_ready;
    logic [31:0] d3_rsp_data;
    logic        d3_rsp_carry, d3_rsp_err;
    logic [3:0]  d3_rsp_tag;
    logic [31:0] d3_alu_a, d3_alu_b, d3_alu_out;
    logic [3:0]  d3_alu_func;
    logic        d3_alu_carry, d3_busy;

    alu32_req_sched #(.WIDTH(32), .ALU_LAT(LAT), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_func(req0_func), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_func(req1_func), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy)
    );

    alu32_req_sched #(.WIDTH(32), .ALU_LAT(LAT3), .TAG_W(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_a(d3_req0_a),
        .req0_b(d3_req0_b), .req0_func(d3_req0_func), .req0_tag(d3_req0_tag),
        .req1_valid(1'b0), .req1_ready(d3_req1_ready), .req1_a(32'd0), .req1_b(32'd0),
        .req1_func(4'd0), .req1_tag(4'd0),
        .rsp0_valid(d3_rsp0_valid), .rsp0_ready(d3_rsp0_ready),
        .rsp1_valid(d3_rsp1_valid), .rsp1_ready(1'b0),
        .rsp_data(d3_rsp_data), .rsp_carry(d3_rsp_carry), .rsp_err(d3_rsp_err),
        .rsp_tag(d3_rsp_tag),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_func(d3_alu_func),
        .alu_out(d3_alu_out), .alu_carry(d3_alu_carry), .busy(d3_busy)
    );

    // Behavioural ALU32 stand-in: {carry, result}.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        logic [32:0] r;
        case (f)
            4'd0:    r = {1'b0, a} + {1'b0, b};
            4'd1:    r = {1'b0, a} - {1'b0, b};
            4'd2:    r = {1'b0, a * b};
            4'd3:    r = {1'b0, (b == 32'd0) ? 32'hDEAD_BEEF : a / b};
            4'd4:    r = {1'b0, a | b};
            4'd5:    r = {1'b0, a ^ b};
            4'd6:    r = {1'b0, a << b[4:0]};
            4'd7:    r = {1'b0, a & b};
            4'd8:    r = {1'b0, a >> b[4:0]};
            default: r = {1'b0, ~a + {28'd0, f}};
        endcase
        return r;
    endfunction

    logic [32:0] pipe1;
    logic [32:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= alu_ref(alu_a, alu_b, alu_func);
        pipe3[0] <= alu_ref(d3_alu_a, d3_alu_b, d3_alu_func);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign {alu_carry, alu_out}       = pipe1;
    assign {d3_alu_carry, d3_alu_out} = pipe3[2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Transaction-level model state.
    int          ptr_m;
    logic [31:0] last_a, last_b;
    logic [3:0]  last_f;
    bit          pend [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [3:0]  pf [2];
    logic [3:0]  pt [2];

    task automatic drive_req();
        req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_func = pf[0]; req0_tag = pt[0];
        req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_func = pf[1]; req1_tag = pt[1];
    endtask

    task automatic post(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input logic [3:0] t);
        pend[n] = 1'b1; pa[n] = a; pb[n] = b; pf[n] = f; pt[n] = t;
        drive_req();
    endtask

    function automatic logic rdy(input int n);
        return (n == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rvld(input int n);
        return (n == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic set_rsp_ready(input int n, input logic v);
        if (n == 1) rsp1_ready = v; else rsp0_ready = v;
    endtask

    task automatic model_reset();
        ptr_m = 0; last_a = '0; last_b = '0; last_f = '0;
        for (int n = 0; n < 2; n++) begin
            pend[n] = 1'b0; pa[n] = '0; pb[n] = '0; pf[n] = '0; pt[n] = '0;
        end
        drive_req();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    // Called in an IDLE cycle with at least one request pending; runs one full transaction.
    task automatic serve(input int bp, input string nm, output logic [31:0] data_o);
        int          g, lat, k;
        bit          div0;
        logic [32:0] r;
        logic [31:0] ed;
        logic        ec;
        #1;
        g = pend[ptr_m] ? ptr_m : 1 - ptr_m;
        check({nm, "_ready_win"}, rdy(g), 1);
        check({nm, "_ready_lose"}, rdy(1 - g), 0);
        div0 = (pf[g] == 4'd3) && (pb[g] == 32'd0);
        r    = alu_ref(pa[g], pb[g], pf[g]);
        ed   = div0 ? 32'hFFFF_FFFF : r[31:0];
        ec   = div0 ? 1'b0 : r[32];
        lat  = div0 ? 1 : LAT + 2;
        if (!div0) begin
            last_a = pa[g]; last_b = pb[g]; last_f = pf[g];
        end
        ptr_m = 1 - g;
        @(posedge clk); #1;
        pend[g] = 1'b0;
        drive_req();
        #1;
        k = 1;
        while (!(rsp0_valid || rsp1_valid) && k < 50) begin
            check({nm, "_wait_busy"}, busy, 1);
            check({nm, "_wait_noready"}, {req0_ready, req1_ready}, 0);
            check({nm, "_wait_alu"}, {alu_a, alu_b, 28'd0, alu_func}, {last_a, last_b, 28'd0, last_f});
            @(posedge clk); #2;
            k++;
        end
        check({nm, "_latency"}, k, lat);
        check({nm, "_rsp_owner"}, rvld(g), 1);
        check({nm, "_rsp_other"}, rvld(1 - g), 0);
        check({nm, "_data"}, rsp_data, ed);
        check({nm, "_carry_err_tag"}, {rsp_carry, rsp_err, rsp_tag}, {ec, div0, pt[g]});
        check({nm, "_alu_hold"}, {alu_a, alu_b, 28'd0, alu_func}, {last_a, last_b, 28'd0, last_f});
        data_o = rsp_data;
        for (int i = 0; i < bp; i++) begin
            set_rsp_ready(1 - g, 1'b1);
            @(posedge clk); #2;
            check({nm, "_bp_valid"}, rvld(g), 1);
            check({nm, "_bp_stable"}, {rsp_data, rsp_carry, rsp_err, rsp_tag}, {ed, ec, div0, pt[g]});
            check({nm, "_bp_busy_noready"}, {busy, req0_ready, req1_ready}, 3'b100);
        end
        set_rsp_ready(1 - g, 1'b0);
        set_rsp_ready(g, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(g, 1'b0);
        #1;
        check({nm, "_retired"}, {busy, rsp0_valid, rsp1_valid}, 3'b000);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] rb;
        logic [3:0]  rf;
        int          k;

        d3_req0_valid = 1'b0; d3_req0_a = '0; d3_req0_b = '0;
        d3_req0_func = '0; d3_req0_tag = '0; d3_rsp0_ready = 1'b0;
        do_reset();

        check("reset_ctrl", {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
        check("reset_rsp", {rsp_data, rsp_carry, rsp_err, rsp_tag}, 0);
        check("reset_alu", {alu_a, alu_b, alu_func}, 0);

        // Single add on req0.
        post(0, 32'd5, 32'd7, 4'b0000, 4'd3);
        serve(0, "add", d);
        check("add_data12", d, 32'd12);

        // Simultaneous pairs from a fresh pointer.
        do_reset();
        post(0, 32'd9, 32'd4, 4'b0001, 4'd1);
        post(1, 32'd6, 32'd3, 4'b0111, 4'd2);
        serve(0, "pair_a", d);
        check("pair_a_data5", d, 32'd5);
        serve(0, "pair_b", d);
        check("pair_b_data2", d, 32'd2);
        post(0, 32'd20, 32'd22, 4'b0000, 4'd4);
        post(1, 32'd8, 32'd2, 4'b0001, 4'd5);
        serve(0, "pair_c", d);
        check("pair_c_req0_first", d, 32'd42);
        serve(1, "pair_d", d);

        // Divide by zero on req1.
        post(1, 32'd100, 32'd0, 4'b0011, 4'd9);
        serve(0, "div0", d);
        check("div0_data", d, 32'hFFFF_FFFF);

        // Backpressure with a competing request held valid throughout.
        post(0, 32'hFFFF_FFFF, 32'd1, 4'b0000, 4'd6);
        post(1, 32'd50, 32'd7, 4'b0001, 4'd7);
        serve(10, "bp", d);
        serve(0, "after_bp", d);

        // Reset during WAIT aborts the transaction.
        post(0, 32'd11, 32'd22, 4'b0000, 4'd8);
        #1;
        check("abort_accept", req0_ready, 1);
        @(posedge clk); #1;
        pend[0] = 1'b0;
        drive_req();
        @(posedge clk); #2;
        check("abort_in_wait_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("abort_outputs", {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
        check("abort_rsp", {rsp_data, rsp_carry, rsp_err, rsp_tag}, 0);
        check("abort_alu", {alu_a, alu_b, alu_func}, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            check("abort_no_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
        end
        post(0, 32'd1, 32'd2, 4'b0000, 4'd1);
        post(1, 32'd3, 32'd4, 4'b0000, 4'd2);
        serve(0, "post_abort", d);
        check("post_abort_req0", d, 32'd3);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && ($urandom_range(0, 1) == 1)) begin
                    rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                    rf = ($urandom_range(0, 4) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
                    post(n, $urandom, rb, rf, 4'($urandom_range(0, 15)));
                end
            end
            if (!pend[0] && !pend[1]) begin
                post(0, $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            serve($urandom_range(0, 3), "rand", d);
        end

        // Three-cycle ALU instance.
        d3_req0_valid = 1'b1; d3_req0_a = 32'd3; d3_req0_b = 32'd4;
        d3_req0_func = 4'b0010; d3_req0_tag = 4'd5;
        #1;
        check("lat3_ready", d3_req0_ready, 1);
        @(posedge clk); #1;
        d3_req0_valid = 1'b0;
        #1;
        k = 1;
        while (!d3_rsp0_valid && k < 20) begin
            check("lat3_busy", d3_busy, 1);
            check("lat3_alu_hold", {d3_alu_a, d3_alu_b, d3_alu_func}, {32'd3, 32'd4, 4'b0010});
            @(posedge clk); #2;
            k++;
        end
        check("lat3_latency", k, LAT3 + 2);
        check("lat3_data", d3_rsp_data, 32'd12);
        check("lat3_flags", {d3_rsp_carry, d3_rsp_err, d3_rsp_tag, d3_rsp1_valid}, {2'b00, 4'd5, 1'b0});
        d3_rsp0_ready = 1'b1;
        @(posedge clk); #1;
        d3_rsp0_ready = 1'b0;
        #1;
        check("lat3_retired", {d3_busy, d3_rsp0_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
